// File: rtl/wb_pkg.sv
// Shared widths and the FIFO entry type for the Wishbone instruction prefetcher.
package wb_pkg;
  localparam int DW = 16;
  localparam int AW = 16;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [AW-1:0] adr;
  } fifo_entry_t;
endpackage

// File: rtl/if_wb.sv
// Pipelined Wishbone read bus bundle shared by the fetch master and its slave.
interface if_wb (input logic clk);
  import wb_pkg::*;

  logic          rst;
  logic          cyc;
  logic          stb;
  logic          we;
  logic [AW-1:0] adr;
  logic [DW-1:0] dat_i;
  logic          ack;
  logic          stall;

  modport master (input clk, rst, dat_i, ack, stall, output cyc, stb, we, adr);
  modport slave  (input clk, rst, cyc, stb, we, adr, output dat_i, ack, stall);
endinterface

// File: rtl/fifo_sync.sv
// Shift-style synchronous FIFO: slot 0 is always the head, so the output is a plain register.
module fifo_sync
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic                   i_flush,
  input  fifo_entry_t            i_din,
  output fifo_entry_t            o_dout,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;

  logic [CW-1:0] r_count;
  fifo_entry_t   r_mem     [DEPTH];
  fifo_entry_t   w_mem_nxt [DEPTH];
  logic          w_do_pop;
  logic          w_do_push;
  logic [CW-1:0] w_wr_idx;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == CW'(0));
  assign o_count   = r_count;
  assign o_dout    = r_mem[0];
  assign w_do_pop  = i_pop & ~o_empty;
  // A pop in the same cycle frees a slot, so a full FIFO can still accept a push.
  assign w_do_push = i_push & (~o_full | w_do_pop);
  assign w_wr_idx  = w_do_pop ? (r_count - CW'(1)) : r_count;

  // Next slot contents: shift towards the head on pop, write the tail on push.
  always_comb begin
    w_mem_nxt = r_mem;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_do_push && (w_wr_idx == CW'(i))) begin
        w_mem_nxt[i] = i_din;
      end else if (w_do_pop) begin
        w_mem_nxt[i] = r_mem[(i + 1) % DEPTH];
      end else begin
        w_mem_nxt[i] = r_mem[i];
      end
    end
  end

  // Data slots carry no reset; only the occupancy count decides validity.
  always_ff @(posedge i_clk) begin
    r_mem <= w_mem_nxt;
  end

  // Occupancy count; flush empties the FIFO and overrides any push or pop.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_count <= CW'(0);
    end else begin
      r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
    end
  end
endmodule

// File: rtl/wb_prefetch.sv
// Instruction prefetcher: streams sequential reads over pipelined Wishbone into a FIFO,
// with jump redirection that discards responses still in flight.
module wb_prefetch
  import wb_pkg::*;
#(
  parameter int            DEPTH     = 4,
  parameter logic [AW-1:0] RESET_ADR = 16'h0000
) (
  if_wb.master           wb,
  input  logic           i_jump,
  input  logic [AW-1:0]  i_jump_adr,
  output logic [DW-1:0]  o_insn,
  output logic [AW-1:0]  o_insn_adr,
  output logic           o_insn_valid,
  input  logic           i_insn_ready
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = CW + 1;

  logic [AW-1:0] r_fetch_adr;
  logic [AW-1:0] r_resp_adr;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_discard;

  logic          w_stb;
  logic          w_accept;
  logic          w_push;
  logic          w_pop;
  logic [SW-1:0] w_inflight;
  logic [CW-1:0] w_fifo_count;
  logic          w_fifo_full;
  logic          w_fifo_empty;
  fifo_entry_t   w_fifo_in;
  fifo_entry_t   w_fifo_out;

  // Every slot is reserved at request time, so the FIFO can never overflow.
  assign w_inflight = {1'b0, w_fifo_count} + {1'b0, r_outstanding};
  assign w_stb      = ~wb.rst & ~i_jump & (w_inflight < SW'(DEPTH));
  assign w_accept   = w_stb & ~wb.stall;
  assign w_push     = wb.ack & ~i_jump & (r_discard == CW'(0)) & ~w_fifo_full;
  assign w_pop      = o_insn_valid & i_insn_ready & ~i_jump;

  assign wb.stb  = w_stb;
  assign wb.cyc  = ~wb.rst & (w_stb | (r_outstanding != CW'(0)));
  assign wb.we   = 1'b0;
  assign wb.adr  = r_fetch_adr;

  assign w_fifo_in.data = wb.dat_i;
  assign w_fifo_in.adr  = r_resp_adr;

  assign o_insn       = w_fifo_out.data;
  assign o_insn_adr   = w_fifo_out.adr;
  assign o_insn_valid = ~wb.rst & ~w_fifo_empty;

  // Request/response bookkeeping; r_resp_adr names the next response that will be kept.
  always_ff @(posedge wb.clk) begin
    if (wb.rst) begin
      r_fetch_adr   <= RESET_ADR;
      r_resp_adr    <= RESET_ADR;
      r_outstanding <= CW'(0);
      r_discard     <= CW'(0);
    end else begin
      r_outstanding <= r_outstanding + CW'(w_accept) - CW'(wb.ack);
      if (i_jump) begin
        r_fetch_adr <= i_jump_adr;
        r_resp_adr  <= i_jump_adr;
        r_discard   <= r_outstanding - CW'(wb.ack);
      end else begin
        if (w_accept) begin
          r_fetch_adr <= r_fetch_adr + AW'(1);
        end
        if (w_push) begin
          r_resp_adr <= r_resp_adr + AW'(1);
        end
        if (wb.ack && (r_discard != CW'(0))) begin
          r_discard <= r_discard - CW'(1);
        end
      end
    end
  end

  fifo_sync #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .i_clk   (wb.clk),
    .i_rst   (wb.rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (i_jump),
    .i_din   (w_fifo_in),
    .o_dout  (w_fifo_out),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );
endmodule

// File: tb/tb_wb_prefetch.sv
// Bench for wb_prefetch: in-order slave with random latency/stall and a stream-level model.
module tb_wb_prefetch;
  import wb_pkg::*;

  localparam int          DEPTH   = 4;
  localparam logic [15:0] RST_ADR = 16'h0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  if_wb bus (.clk(clk));

  logic        jump;
  logic [15:0] jump_adr;
  logic [15:0] insn;
  logic [15:0] insn_adr;
  logic        insn_valid;
  logic        insn_ready;

  wb_prefetch #(.DEPTH(DEPTH), .RESET_ADR(RST_ADR)) dut (
    .wb           (bus),
    .i_jump       (jump),
    .i_jump_adr   (jump_adr),
    .o_insn       (insn),
    .o_insn_adr   (insn_adr),
    .o_insn_valid (insn_valid),
    .i_insn_ready (insn_ready)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Slave: queue of accepted requests, each with the cycle its ack may come and a stale flag.
  logic [15:0] q_adr[$];
  int          q_due[$];
  bit          q_stale[$];

  // Stream model: words sitting in the FIFO, next expected word, next expected request.
  int          fifo_n, cyc_cnt, lat, ack_pct, accepts, n_cons;
  logic [15:0] exp_adr, req_adr, last_cons;
  bit          prev_hold_bus, prev_hold_insn;
  logic [15:0] prev_adr, prev_insn, prev_insn_adr;

  function automatic logic [15:0] fdat(input logic [15:0] a);
    return a + 16'h1000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q_adr.delete(); q_due.delete(); q_stale.delete();
    fifo_n = 0; exp_adr = RST_ADR; req_adr = RST_ADR;
    prev_hold_bus = 1'b0; prev_hold_insn = 1'b0;
  endtask

  task automatic tick();
    logic ack_now, exp_stb, acc, cons;
    ack_now = 1'b0;
    if (!bus.rst && q_adr.size() != 0 && q_due[0] <= cyc_cnt &&
        $urandom_range(0, 99) < ack_pct)
      ack_now = 1'b1;
    bus.ack   = ack_now;
    bus.dat_i = ack_now ? fdat(q_adr[0]) : 16'($urandom);
    @(negedge clk);
    if (bus.rst) begin
      chk("rst_stb",   32'(bus.stb),    32'd0);
      chk("rst_cyc",   32'(bus.cyc),    32'd0);
      chk("rst_we",    32'(bus.we),     32'd0);
      chk("rst_valid", 32'(insn_valid), 32'd0);
      model_reset();
    end else begin
      exp_stb = !jump && ((q_adr.size() + fifo_n) < DEPTH);
      chk("stb",   32'(bus.stb),    32'(exp_stb));
      chk("cyc",   32'(bus.cyc),    32'(exp_stb || q_adr.size() != 0));
      chk("we",    32'(bus.we),     32'd0);
      chk("valid", 32'(insn_valid), 32'(fifo_n != 0));
      if (prev_hold_bus && !jump) chk("adr_hold", 32'(bus.adr), 32'(prev_adr));
      if (prev_hold_insn) begin
        chk("insn_hold",     32'(insn),     32'(prev_insn));
        chk("insn_adr_hold", 32'(insn_adr), 32'(prev_insn_adr));
      end
      acc  = bus.stb && !bus.stall;
      cons = insn_valid && insn_ready && !jump;
      if (cons) begin
        chk("insn_adr", 32'(insn_adr), 32'(exp_adr));
        chk("insn",     32'(insn),     32'(fdat(exp_adr)));
        last_cons = insn_adr;
        n_cons++;
        exp_adr++;
        if (fifo_n > 0) fifo_n--;
      end
      if (ack_now) begin
        if (!q_stale[0] && !jump) fifo_n++;
        void'(q_adr.pop_front()); void'(q_due.pop_front()); void'(q_stale.pop_front());
      end
      if (acc) begin
        chk("req_adr", 32'(bus.adr), 32'(req_adr));
        q_adr.push_back(bus.adr); q_due.push_back(cyc_cnt + lat); q_stale.push_back(1'b0);
        req_adr++;
        accepts++;
      end
      if (jump) begin
        foreach (q_stale[i]) q_stale[i] = 1'b1;
        fifo_n = 0; exp_adr = jump_adr; req_adr = jump_adr;
      end
      chk("outstanding_max", 32'(q_adr.size() <= DEPTH), 32'd1);
      prev_hold_bus  = bus.stb && bus.stall && !jump;
      prev_adr       = bus.adr;
      prev_hold_insn = insn_valid && !insn_ready && !jump;
      prev_insn      = insn;
      prev_insn_adr  = insn_adr;
    end
    @(posedge clk);
    #1;
    cyc_cnt++;
  endtask

  task automatic do_reset();
    bus.rst = 1'b1; jump = 1'b0;
    tick(); tick();
    bus.rst = 1'b0;
  endtask

  initial begin
    int n0;
    logic [15:0] e;
    bus.rst = 1'b1; bus.stall = 1'b0; bus.ack = 1'b0; bus.dat_i = 16'h0000;
    jump = 1'b0; jump_adr = 16'h0000; insn_ready = 1'b1;
    lat = 1; ack_pct = 100; cyc_cnt = 0; accepts = 0; n_cons = 0; last_cons = 16'h0000;
    model_reset();
    repeat (3) tick();

    // Zero-wait slave, consumer always ready: continuous stream from cycle 3.
    bus.rst = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      #1;
      if (k == 1) begin
        chk("first_stb", 32'(bus.stb), 32'd1);
        chk("first_adr", 32'(bus.adr), 32'(RST_ADR));
      end
      if (k >= 3) chk("stream_valid", 32'(insn_valid), 32'd1);
      tick();
    end

    // Consumer stalls: exactly DEPTH requests, then resume without loss.
    do_reset();
    insn_ready = 1'b0; accepts = 0;
    repeat (20) tick();
    chk("backpressure_reqs", 32'(accepts), 32'd4);
    #1;
    chk("backpressure_head", 32'(insn_adr), 32'h0);
    insn_ready = 1'b1;
    repeat (12) tick();

    // Bus stall on the very first request.
    do_reset();
    bus.stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("stall_stb", 32'(bus.stb), 32'd1);
      chk("stall_adr", 32'(bus.adr), 32'h0);
      tick();
    end
    bus.stall = 1'b0;
    repeat (10) tick();

    // Slow slave, jump with three responses in flight.
    do_reset();
    lat = 3;
    for (int k = 0; k < 20 && q_adr.size() != 3; k++) tick();
    chk("three_outstanding", 32'(q_adr.size()), 32'd3);
    jump = 1'b1; jump_adr = 16'h0200;
    tick();
    jump = 1'b0;
    n0 = n_cons;
    for (int k = 0; k < 30 && n_cons == n0; k++) tick();
    chk("jump_first_adr", 32'(last_cons), 32'h0200);

    // Address wrap after jumping near the top of the space.
    lat = 1;
    jump = 1'b1; jump_adr = 16'hFFFE;
    tick();
    jump = 1'b0;
    for (int j = 0; j < 4; j++) begin
      n0 = n_cons;
      for (int k = 0; k < 20 && n_cons == n0; k++) tick();
      e = 16'hFFFE + 16'(j);
      chk("wrap_adr", 32'(last_cons), 32'(e));
    end

    // Reset with two requests outstanding and a non-empty FIFO.
    do_reset();
    lat = 3; insn_ready = 1'b0;
    for (int k = 0; k < 40 && !(q_adr.size() == 2 && fifo_n > 0); k++) tick();
    chk("pre_reset_state", 32'(q_adr.size() == 2 && fifo_n > 0), 32'd1);
    bus.rst = 1'b1;
    tick();
    bus.rst = 1'b0;
    #1;
    chk("post_reset_stb", 32'(bus.stb), 32'd1);
    chk("post_reset_adr", 32'(bus.adr), 32'(RST_ADR));
    insn_ready = 1'b1; lat = 1;
    repeat (10) tick();

    // Random traffic: stalls, latency, back-pressure, jumps (incl. back-to-back), resets.
    ack_pct = 70;
    for (int i = 0; i < 3000; i++) begin
      bus.stall  = ($urandom_range(0, 3) == 0);
      insn_ready = ($urandom_range(0, 3) != 0);
      lat        = $urandom_range(1, 4);
      bus.rst    = ($urandom_range(0, 199) == 0);
      jump       = ($urandom_range(0, 11) == 0);
      jump_adr   = ($urandom_range(0, 1) == 1) ? (16'hFFFC + 16'($urandom_range(0, 3)))
                                               : 16'($urandom);
      tick();
    end
    bus.rst = 1'b0; jump = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/wb_prefetch.md
WB_PREFETCH -- requirements
Module: wb_prefetch

Interface
REQ-001 Parameters SHALL be: DEPTH, default 4, prefetch FIFO entries (power of two, minimum 2); RESET_ADR, default 16'h0000, first fetch address after reset.
REQ-002 wb.clk  input  1  single clock for all logic, delivered via if_wb.master modport.
REQ-003 wb.rst  input  1  reset, synchronous, active-high.
REQ-004 wb.cyc  output  1  bus cycle active.
REQ-005 wb.stb  output  1  read request strobe.
REQ-006 wb.we  output  1  write enable, constant 0.
REQ-007 wb.adr  output  16  word address of the request.
REQ-008 wb.dat_i  input  16  read data, valid with wb.ack.
REQ-009 wb.ack  input  1  one response per accepted request, in order.
REQ-010 wb.stall  input  1  slave not accepting the request this cycle.
REQ-011 jump  input  1  redirect fetch stream, single-cycle pulse.
REQ-012 jump_adr  input  16  new fetch address, sampled when jump=1.
REQ-013 insn  output  16  instruction word at FIFO head.
REQ-014 insn_adr  output  16  word address of insn.
REQ-015 insn_valid  output  1  FIFO head valid.
REQ-016 insn_ready  input  1  consumer takes head when insn_valid & insn_ready.

Function
REQ-017 Bus protocol SHALL be Wishbone classic pipelined: request accepted in a cycle with cyc & stb & ~stall; adr SHALL stay stable while stb=1 and stall=1.
REQ-018 fetch_adr counter SHALL drive wb.adr and increment by 1 (16-bit wrap FFFF->0000) on each accepted request.
REQ-019 Counter outstanding (0..DEPTH) SHALL increment on accept, decrement on ack, and stay unchanged when both occur in one cycle.
REQ-020 stb SHALL be asserted iff ~jump and (fifo_count + outstanding) < DEPTH; fifo_count + outstanding SHALL never exceed DEPTH, so FIFO overflow is impossible.
REQ-021 cyc SHALL equal stb | (outstanding != 0).
REQ-022 On ack with discard=0: push {dat_i, address of that request} into FIFO; each entry's address SHALL equal fetch_adr at that request's acceptance.
REQ-023 FIFO SHALL support simultaneous push and pop in one cycle, including when full (pop frees slot) and when empty (data not bypassed; valid next cycle).
REQ-024 On jump: FIFO SHALL be flushed (insn_valid=0 next cycle); fetch_adr <= jump_adr; discard <= outstanding minus any ack in the same cycle; no request issued that cycle.
REQ-025 While discard != 0 each ack SHALL decrement discard and be dropped, not pushed.
REQ-026 Jump in the same cycle as an ack: that ack's data SHALL be dropped.
REQ-027 Jump in the same cycle as insn_valid & insn_ready: pop is void; flush wins.
REQ-028 Back-to-back jumps SHALL be handled; the last jump_adr wins and discard tracks all still-outstanding responses.
REQ-029 Latency to a zero-wait slave (ack one cycle after accept): request in cycle N, insn_valid in cycle N+2; sustained throughput 1 word/cycle when insn_ready=1 and DEPTH>=3.
REQ-030 insn and insn_adr SHALL be registered FIFO outputs, stable while insn_valid=1 and insn_ready=0.

Reset
REQ-031 While wb.rst=1 (sampled on wb.clk): stb=0, cyc=0, we=0, insn_valid=0, outstanding=0, discard=0, FIFO empty, fetch_adr=RESET_ADR.
REQ-032 Reset mid-transaction SHALL abandon all outstanding responses; the slave is reset by the same wb.rst, so no stale acks follow.
REQ-033 First request SHALL be issued in the first cycle after wb.rst deasserts, with adr=RESET_ADR.
REQ-034 insn, insn_adr data registers need no reset; their values are don't-care while insn_valid=0.

Structure
REQ-035 Shared package wb_pkg SHALL hold the data-width constant (16), address-width constant (16) and a typedef for the FIFO entry struct {data, adr}.
REQ-036 FIFO SHALL be sub-module fifo_sync (parameter DEPTH, entry type from wb_pkg, ports push, pop, flush, full, empty, count); control counters stay in wb_prefetch.
REQ-037 Bus side SHALL use the existing if_wb interface, master modport.

Verification
REQ-038 Reset release with zero-wait slave returning adr+16'h1000 as data, insn_ready=1 -> insn sequence 1000,1001,1002... with insn_adr 0,1,2..., insn_valid continuous from cycle 3.
REQ-039 insn_ready=0 for 20 cycles -> exactly DEPTH(4) requests issued, stb drops, FIFO holds adr 0..3; ready=1 -> fetching resumes at adr 4, no word lost or duplicated.
REQ-040 stall=1 for 3 cycles on first request -> adr holds 0000 with stb=1; one ack per accepted request; outstanding never >4.
REQ-041 Slave with 3-cycle ack latency, jump to 0x0200 while 3 requests outstanding -> 3 acks dropped, next insn_adr=0x0200, no stale word delivered.
REQ-042 jump_adr=16'hFFFE -> insn_adr FFFE, FFFF, 0000, 0001 (wrap).
REQ-043 wb.rst asserted with 2 requests outstanding and FIFO non-empty -> next cycle cyc=0, insn_valid=0; after release first adr=RESET_ADR.
